// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern recorder/replayer controller.
package pattern_pkg;

  // Controller state encoding, also exported on the state port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    ARM    = 2'd2,
    PLAY   = 2'd3
  } state_e;

  // Default depth of the external pattern memory, in entries.
  localparam int unsigned MAX_LEN_DEFAULT = 255;

endpackage : pattern_pkg

// File: rtl/pattern_ctrl.sv
// Pattern controller: records a byte stream into an external memory and
// hands the recorded length to an external replayer for looped playback.
module pattern_ctrl
  import pattern_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_record,
  input  logic       btn_play,
  input  logic       btn_stop,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       mem_we,
  output logic       mem_re,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       rep_start,
  output logic       rep_enable,
  output logic [7:0] rep_limit,
  input  logic       rep_read,
  input  logic [7:0] rep_addr,
  output logic [1:0] state,
  output logic [7:0] count,
  output logic       full
);

  localparam logic [7:0] MaxCnt = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       xfer;

  // Record-stream handshake; count doubles as the write pointer.
  always_comb begin
    wr_ready = (state_q == RECORD) && (count_q < MaxCnt);
    xfer     = wr_valid && wr_ready;
  end

  // Next state and next count; stop beats record beats play.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (btn_stop) begin
      state_d = IDLE;
    end else if (btn_record) begin
      state_d = RECORD;
      count_d = '0;
    end else begin
      if (xfer) begin
        count_d = count_q + 8'd1;
      end
      unique case (state_q)
        // Play is judged on the count including a same-cycle write, so
        // the length handed to the replayer already contains that entry.
        IDLE, RECORD: if (btn_play && (count_d != '0)) state_d = ARM;
        ARM:          state_d = PLAY;
        default:      ;
      endcase
    end
  end

  // State and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Memory port muxing and replayer handoff.
  always_comb begin
    mem_we     = xfer;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = xfer ? wr_data : '0;
    rep_start  = (state_q == ARM);
    rep_enable = (state_q == PLAY);
    unique case (state_q)
      RECORD: mem_addr = count_q;
      PLAY: begin
        mem_addr = rep_addr;
        mem_re   = rep_read;
      end
      default: ;
    endcase
  end

  // Status outputs.
  always_comb begin
    state     = state_q;
    count     = count_q;
    rep_limit = count_q;
    full      = (count_q == MaxCnt);
  end

endmodule : pattern_ctrl

// File: doc/pattern_ctrl.md
PATTERN_CTRL -- requirements
Module: pattern_ctrl

Interface
REQ-001 Parameter: MAX_LEN, default 255, maximum number of recorded entries (legal range 1..255).
REQ-002 Port: clk  in  1  single clock, all logic on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous reset, active low.
REQ-004 Port: btn_record  in  1  one-cycle request: begin a new recording.
REQ-005 Port: btn_play  in  1  one-cycle request: begin looped replay.
REQ-006 Port: btn_stop  in  1  one-cycle request: return to idle.
REQ-007 Port: wr_valid  in  1  record-stream data valid.
REQ-008 Port: wr_data  in  8  record-stream data byte.
REQ-009 Port: wr_ready  out  1  record-stream accept; a transfer occurs when wr_valid and wr_ready are both high.
REQ-010 Port: mem_we  out  1  pattern memory write strobe.
REQ-011 Port: mem_re  out  1  pattern memory read strobe.
REQ-012 Port: mem_addr  out  8  pattern memory address.
REQ-013 Port: mem_wdata  out  8  pattern memory write data.
REQ-014 Port: rep_start  out  1  replayer initialise pulse.
REQ-015 Port: rep_enable  out  1  replayer run enable.
REQ-016 Port: rep_limit  out  8  replayer sequence length.
REQ-017 Port: rep_read  in  1  replayer memory read request.
REQ-018 Port: rep_addr  in  8  replayer address; undriven (z) while rep_enable is low.
REQ-019 Port: state  out  2  current state encoding.
REQ-020 Port: count  out  8  number of valid recorded entries.
REQ-021 Port: full  out  1  high when count == MAX_LEN.

Function
REQ-022 States: IDLE=0, RECORD=1, ARM=2, PLAY=3; state SHALL be registered.
REQ-023 Request priority when several arrive in one cycle: btn_stop > btn_record > btn_play.
REQ-024 btn_stop in any state SHALL move to IDLE next cycle and SHALL leave count unchanged.
REQ-025 btn_record in IDLE, ARM or PLAY SHALL move to RECORD and clear count and the write pointer to 0; in RECORD it SHALL restart the recording identically.
REQ-026 btn_play in IDLE or RECORD with count > 0 SHALL move to ARM; with count == 0 it SHALL be ignored; in ARM or PLAY it SHALL be ignored.
REQ-027 A write accepted in the same cycle as btn_play SHALL be committed and counted, and the count used for replay SHALL include it.
REQ-028 wr_ready SHALL equal (state == RECORD) and (count < MAX_LEN); it is combinational.
REQ-029 On a transfer, mem_we=1, mem_addr=count and mem_wdata=wr_data in the same cycle (combinational); count SHALL increment on the next edge.
REQ-030 At count == MAX_LEN the block SHALL remain in RECORD with wr_ready=0 and full=1, and no write SHALL occur.
REQ-031 ARM SHALL last exactly one cycle, with rep_start=1 and rep_enable=0, then move to PLAY.
REQ-032 In PLAY: rep_enable=1, mem_addr=rep_addr, mem_re=rep_read, mem_we=0.
REQ-033 Outside PLAY, mem_re=0; outside RECORD and PLAY, mem_addr=0.
REQ-034 rep_limit SHALL equal count at all times; count is constant in ARM and PLAY.
REQ-035 rep_start and rep_enable SHALL never be high in the same cycle.
REQ-036 rep_enable SHALL drop in the cycle after btn_stop or btn_record is sampled in PLAY.

Reset
REQ-037 While rst_n is low: state=IDLE, count=0, and wr_ready, mem_we, mem_re, rep_start, rep_enable and full all 0.
REQ-038 Reset asserted mid-RECORD or mid-PLAY SHALL discard the recording (count=0); no memory write SHALL occur during reset.

Structure
REQ-039 The state encoding and the default MAX_LEN value SHALL reside in the shared package pattern_pkg.
REQ-040 The design SHALL be a single module with no sub-modules; the memory and the replayer are external.

Verification
REQ-041 Scenario: reset, btn_record, stream 3 bytes 0xA1,0xA2,0xA3 -> writes to addresses 0,1,2; count=3.
REQ-042 Scenario: btn_play -> exactly one cycle with rep_start=1, then rep_enable=1 and rep_limit=3; mem_addr tracks rep_addr and mem_re tracks rep_read.
REQ-043 Scenario: MAX_LEN=4, stream 6 bytes -> only 4 written; full=1; wr_ready=0 thereafter.
REQ-044 Scenario: btn_play from IDLE with count=0 -> state stays IDLE; rep_start never asserted.
REQ-045 Scenario: btn_stop, btn_record and btn_play in the same cycle during PLAY -> IDLE next cycle; count unchanged.
REQ-046 Scenario: btn_play in the same cycle as the 2nd accepted write -> ARM; rep_limit=2.
